// File: rtl/sc_bitstream_gen.sv
// sc_bitstream_gen
//   Binary-to-stochastic converter. A WIDTH-bit unsigned value is accepted
//   over a valid/ready handshake. The block then emits one bit per accepted
//   beat. Over one stream period, the number of ones in the stream equals
//   the value. Each bit is the result of (value_q > rng).
//   RNG_MODE=0 uses a bit-reversed counter as rng, giving a period of
//   2^WIDTH beats. RNG_MODE=1 uses a Fibonacci LFSR minus one as rng,
//   giving a period of 2^WIDTH-1 beats.
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   in_valid/in_ready   input handshake; in_data is the value to encode
//   abort               synchronous; drops the current stream and returns to IDLE
//   out_ready           downstream accepts out_bit this cycle (0 = stall)
//   out_valid, out_bit  stochastic bit stream
//   out_last            final beat of the stream period
module sc_bitstream_gen #(
    parameter int              WIDTH    = 8,
    parameter int              RNG_MODE = 0,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'('hB8),
    parameter logic [WIDTH-1:0] SEED    = WIDTH'('h01)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last
);

    // Index of the final beat within one stream period.
    localparam logic [WIDTH-1:0] LAST = (RNG_MODE == 0) ? {WIDTH{1'b1}}
                                                        : {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] rng;
    logic             origin;   // restart cnt and rng at the beginning of a period
    logic             step;     // advance cnt and rng by one beat

    // RNG source. It only moves with cnt, so a stalled beat keeps its bit.
    generate
        if (RNG_MODE == 0) begin : g_rev
            always_comb begin
                rng = '0;
                for (int i = 0; i < WIDTH; i++) rng[i] = cnt_q[WIDTH-1-i];
            end
        end else begin : g_lfsr
            logic [WIDTH-1:0] lfsr_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      lfsr_q <= SEED;
                else if (origin) lfsr_q <= SEED;
                else if (step)   lfsr_q <= {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
            end
            // The LFSR spans 1..2^W-1, so rng spans 0..2^W-2.
            assign rng = lfsr_q - WIDTH'(1);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        origin    = 1'b0;
        step      = 1'b0;
        out_valid = (state_q == RUN);
        out_last  = out_valid && (cnt_q == LAST);
        out_bit   = out_valid && (value_q > rng);
        in_ready  = !abort && ((state_q == IDLE) || (out_last && out_ready));

        if (abort) begin
            state_d = IDLE;
            origin  = 1'b1;
        end else if (in_valid && in_ready) begin
            // A reload on the final beat goes straight into the next period
            // with no idle cycle.
            value_d = in_data;
            origin  = 1'b1;
            state_d = RUN;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                state_d = IDLE;
                origin  = 1'b1;
            end else begin
                step = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            if (origin)    cnt_q <= '0;
            else if (step) cnt_q <= cnt_q + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sc_bitstream_gen.sv
// Randomized bench for sc_bitstream_gen. One instance is built per RNG
// mode, and sel routes in_valid to one of them. Expected beats come from a
// queue-based model that is filled whenever a handshake is seen.
module tb_sc_bitstream_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, abort, out_ready, sel;
    logic [7:0] in_data;
    logic       r0, ov0, ob0, ol0, r1, ov1, ob1, ol1;
    logic       iv0, iv1;

    assign iv0 = in_valid & ~sel;
    assign iv1 = in_valid & sel;

    always #5 clk = ~clk;

    sc_bitstream_gen #(.WIDTH(8), .RNG_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(r0), .in_data(in_data),
        .abort(abort), .out_ready(out_ready), .out_valid(ov0), .out_bit(ob0), .out_last(ol0));

    sc_bitstream_gen #(.WIDTH(8), .RNG_MODE(1), .TAPS(8'hB8), .SEED(8'h01)) u_m1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(r1), .in_data(in_data),
        .abort(abort), .out_ready(out_ready), .out_valid(ov1), .out_bit(ob1), .out_last(ol1));

    typedef struct packed {logic b; logic l;} beat_t;

    beat_t      q[$];
    int         checks = 0, failures = 0;
    int         hs_cnt = 0, beats = 0, sbeat = 0, ones = 0;
    logic [7:0] cur_v = 8'h00;
    bit         prev_stall = 1'b0;
    logic       prev_b = 1'b0, prev_l = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] brev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Builds the whole period for value v. Each bit is v > rng, and the
    // last flag is set on the final beat only.
    task automatic push_stream(input bit mode, input logic [7:0] v);
        int         len = mode ? 255 : 256;
        logic [7:0] l = 8'h01;
        logic [7:0] rng;
        logic [7:0] k8;
        for (int k = 0; k < len; k++) begin
            k8  = k[7:0];
            rng = mode ? l - 8'd1 : brev(k8);
            q.push_back({v > rng, k == len - 1});
            l = {l[6:0], ^(l & 8'hB8)};
        end
        cur_v = v;
        ones  = 0;
        sbeat = 0;
    endtask

    // One clock. Inputs are set by the caller at the negedge, sampled 1 time
    // unit later, and the task returns at the following negedge.
    task automatic cyc();
        logic  r, ov, ob, ol;
        beat_t e;
        #1;
        r  = sel ? r1 : r0;
        ov = sel ? ov1 : ov0;
        ob = sel ? ob1 : ob0;
        ol = sel ? ol1 : ol0;
        chk("out_valid", ov, q.size() != 0);
        chk("in_ready", r, !abort && (q.size() == 0 || (q.size() == 1 && out_ready)));
        if (!ov) chk("idle_last", ol, 1'b0);
        if (prev_stall) begin
            chk("stall_bit", ob, prev_b);
            chk("stall_last", ol, prev_l);
        end
        if (abort) begin
            q.delete();
        end else if (ov && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("bit", ob, e.b);
            chk("last", ol, e.l);
            ones += int'(ob);
            sbeat++;
            beats++;
            if (e.l) chk("ones", ones, cur_v);
        end
        if (in_valid && r) begin
            hs_cnt++;
            push_stream(sel, in_data);
        end
        prev_stall = ov && !out_ready && !abort;
        prev_b = ob;
        prev_l = ol;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] v);
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = 1'b1;
        cyc();
        in_valid  = 1'b0;
    endtask

    task automatic drain(input bit stall);
        for (int i = 0; i < 3000 && q.size() != 0; i++) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = 8'($urandom);
            cyc();
        end
        chk("drain", q.size(), 0);
        out_ready = 1'b1;
        cyc();
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_rdy0"}, r0, 1'b1);  chk({tag, "_vld0"}, ov0, 1'b0);
        chk({tag, "_bit0"}, ob0, 1'b0); chk({tag, "_lst0"}, ol0, 1'b0);
        chk({tag, "_rdy1"}, r1, 1'b1);  chk({tag, "_vld1"}, ov1, 1'b0);
        chk({tag, "_bit1"}, ob1, 1'b0); chk({tag, "_lst1"}, ol1, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, b0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
        out_ready = 1'b1; sel = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_rst("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0 basic values.
        send(8'h80); drain(1'b0);
        send(8'h00); drain(1'b0);
        send(8'hFF); drain(1'b0);

        // Back-to-back reload with in_valid held high.
        hs0 = hs_cnt; b0 = beats;
        in_valid = 1'b1; in_data = 8'h40;
        for (int i = 0; i < 600 && hs_cnt < hs0 + 2; i++) begin
            if (hs_cnt >= hs0 + 1) in_data = 8'hC0;
            cyc();
        end
        in_valid = 1'b0;
        drain(1'b0);
        chk("b2b_beats", beats - b0, 512);

        // Random stalls.
        send(8'h33); drain(1'b1);
        for (int n = 0; n < 6; n++) begin
            sel = 1'($urandom_range(0, 1));
            send(8'($urandom));
            drain(1'b1);
        end
        sel = 1'b0;

        // Abort at beat 10 while a new value is also offered.
        send(8'h55);
        for (int i = 0; i < 40 && sbeat < 10; i++) cyc();
        chk("abort_pos", sbeat, 10);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
        cyc();
        abort = 1'b0; in_valid = 1'b0;
        cyc();

        // Asynchronous reset at beat 100, then restart.
        send(8'h99);
        for (int i = 0; i < 200 && sbeat < 100; i++) cyc();
        chk("rst_pos", sbeat, 100);
        #2 rst_n = 1'b0;
        #1 chk_rst("midrst");
        q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h80); drain(1'b0);

        // Mode 1 (LFSR).
        sel = 1'b1;
        send(8'hFF); drain(1'b0);
        send(8'h01); drain(1'b0);
        hs0 = hs_cnt; b0 = beats;
        in_valid = 1'b1; in_data = 8'h10;
        for (int i = 0; i < 600 && hs_cnt < hs0 + 2; i++) begin
            if (hs_cnt >= hs0 + 1) in_data = 8'hE0;
            cyc();
        end
        in_valid = 1'b0;
        drain(1'b0);
        chk("m1_b2b_beats", beats - b0, 510);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
